// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the writeback path (A) and the load/debug path (B).
module reg_write_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       A_REQ,
    input  logic [2:0] A_ADDR,
    input  logic [7:0] A_DATA,
    output logic       A_ACK,
    input  logic       B_REQ,
    input  logic [2:0] B_ADDR,
    input  logic [7:0] B_DATA,
    output logic       B_ACK,
    output logic [7:0] RF_IN,
    output logic [2:0] RF_INADDRESS,
    output logic       RF_WRITE,
    output logic       BUSY,
    output logic       LAST_GNT,
    output logic [7:0] WR_COUNT
);

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t              state, state_d;
    logic                pri, pri_d;
    logic [DATA_W-1:0]   rf_in_d;
    logic [ADDR_W-1:0]   rf_addr_d;
    logic                rf_write_d;
    logic                a_ack_d, b_ack_d;
    logic                busy_d;
    logic                last_gnt_d;
    logic [CNT_W-1:0]    wr_count_d;
    logic                gnt_b;

    // Next-state and next-output logic; every registered output has a _d twin.
    always_comb begin
        state_d    = state;
        pri_d      = pri;
        rf_in_d    = RF_IN;
        rf_addr_d  = RF_INADDRESS;
        rf_write_d = 1'b0;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        last_gnt_d = LAST_GNT;
        wr_count_d = WR_COUNT;
        gnt_b      = 1'b0;

        case (state)
            IDLE: begin
                if (A_REQ || B_REQ) begin
                    // A lone requester wins outright; on contention PRI decides.
                    gnt_b      = B_REQ && (!A_REQ || pri);
                    rf_in_d    = gnt_b ? B_DATA : A_DATA;
                    rf_addr_d  = gnt_b ? B_ADDR : A_ADDR;
                    rf_write_d = 1'b1;
                    a_ack_d    = !gnt_b;
                    b_ack_d    = gnt_b;
                    last_gnt_d = gnt_b;
                    pri_d      = !gnt_b;
                    wr_count_d = WR_COUNT + CNT_W'(1);
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                // Blanking cycle: requests are ignored so a winner cannot be granted twice.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == WRITE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            pri          <= RR_INIT;
            RF_IN        <= '0;
            RF_INADDRESS <= '0;
            RF_WRITE     <= 1'b0;
            A_ACK        <= 1'b0;
            B_ACK        <= 1'b0;
            BUSY         <= 1'b0;
            LAST_GNT     <= 1'b0;
            WR_COUNT     <= '0;
        end else begin
            state        <= state_d;
            pri          <= pri_d;
            RF_IN        <= rf_in_d;
            RF_INADDRESS <= rf_addr_d;
            RF_WRITE     <= rf_write_d;
            A_ACK        <= a_ack_d;
            B_ACK        <= b_ack_d;
            BUSY         <= busy_d;
            LAST_GNT     <= last_gnt_d;
            WR_COUNT     <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter with a behavioural 8x8 register file.
module tb_reg_write_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       A_REQ, B_REQ;
    logic [2:0] A_ADDR, B_ADDR;
    logic [7:0] A_DATA, B_DATA;
    logic       A_ACK, B_ACK;
    logic [7:0] RF_IN;
    logic [2:0] RF_INADDRESS;
    logic       RF_WRITE, BUSY, LAST_GNT;
    logic [7:0] WR_COUNT;

    always #5 CLK = ~CLK;

    reg_write_arbiter #(.RR_INIT(1'b0)) dut (
        .CLK(CLK), .RESET(RESET),
        .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_ACK(A_ACK),
        .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_ACK(B_ACK),
        .RF_IN(RF_IN), .RF_INADDRESS(RF_INADDRESS), .RF_WRITE(RF_WRITE),
        .BUSY(BUSY), .LAST_GNT(LAST_GNT), .WR_COUNT(WR_COUNT)
    );

    // Register file model: captures on the write port, clears on reset.
    logic [7:0] rf_mem [8];
    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h00;
        end else if (RF_WRITE) begin
            rf_mem[RF_INADDRESS] <= RF_IN;
        end
    end

    typedef struct packed {
        logic       gnt_b;
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'h00;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_grant(input logic b, input logic [2:0] addr, input logic [7:0] data);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.gnt_b = b;
        e.addr  = addr;
        e.data  = data;
        e.cnt   = exp_cnt;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per write-port cycle.
    bit prev_write = 1'b0;
    always @(negedge CLK) begin
        if (mon_en) begin
            if (RF_WRITE) begin
                check("write_spacing", 32'(prev_write), 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_addr", 32'(RF_INADDRESS), 32'(e.addr));
                    check("sb_data", 32'(RF_IN), 32'(e.data));
                    check("sb_a_ack", 32'(A_ACK), 32'(!e.gnt_b));
                    check("sb_b_ack", 32'(B_ACK), 32'(e.gnt_b));
                    check("sb_last_gnt", 32'(LAST_GNT), 32'(e.gnt_b));
                    check("sb_wr_count", 32'(WR_COUNT), 32'(e.cnt));
                    check("sb_busy", 32'(BUSY), 32'd1);
                end
            end else begin
                check("idle_ack_busy", 32'({A_ACK, B_ACK, BUSY}), 32'd0);
            end
            prev_write = RF_WRITE;
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        A_REQ = 1'b0;
        B_REQ = 1'b0;
        @(negedge CLK);
        RESET   = 1'b0;
        exp_cnt = 8'h00;
    endtask

    initial begin
        int acks;
        int cycles;

        // Reset with both requests high: no grant may occur.
        RESET  = 1'b1;
        A_REQ  = 1'b1; A_ADDR = 3'd1; A_DATA = 8'hAA;
        B_REQ  = 1'b1; B_ADDR = 3'd2; B_DATA = 8'hBB;
        @(posedge CLK);
        @(negedge CLK);
        check("rst_rf_write", 32'(RF_WRITE), 32'd0);
        check("rst_acks", 32'({A_ACK, B_ACK}), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_rf_in", 32'(RF_IN), 32'h00);
        check("rst_rf_addr", 32'(RF_INADDRESS), 32'd0);
        check("rst_last_gnt", 32'(LAST_GNT), 32'd0);
        check("rst_wr_count", 32'(WR_COUNT), 32'h00);
        RESET  = 1'b0;
        A_REQ  = 1'b0;
        B_REQ  = 1'b0;
        mon_en = 1'b1;

        // Single write from A.
        @(negedge CLK);
        A_REQ = 1'b1; A_ADDR = 3'd3; A_DATA = 8'h5A;
        expect_grant(1'b0, 3'd3, 8'h5A);
        @(negedge CLK);
        check("single_rf_write", 32'(RF_WRITE), 32'd1);
        check("single_a_ack", 32'(A_ACK), 32'd1);
        A_REQ = 1'b0;
        @(negedge CLK);
        check("single_rf_write_fall", 32'(RF_WRITE), 32'd0);
        check("single_reg3", 32'(rf_mem[3]), 32'h5A);
        check("single_wr_count", 32'(WR_COUNT), 32'd1);
        check("single_rf_in_hold", 32'(RF_IN), 32'h5A);

        // Round-robin with both requesting for 8 edges.
        do_reset();
        A_REQ = 1'b1; A_ADDR = 3'd4; A_DATA = 8'hA4;
        B_REQ = 1'b1; B_ADDR = 3'd5; B_DATA = 8'hB5;
        expect_grant(1'b0, 3'd4, 8'hA4);
        expect_grant(1'b1, 3'd5, 8'hB5);
        expect_grant(1'b0, 3'd4, 8'hA4);
        expect_grant(1'b1, 3'd5, 8'hB5);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("rr_write_edge", 32'(RF_WRITE), 32'((i % 2) == 0));
            if ((i % 2) == 0) check("rr_last_gnt", 32'(LAST_GNT), 32'((i / 2) % 2));
        end
        A_REQ = 1'b0;
        B_REQ = 1'b0;
        check("rr_wr_count", 32'(WR_COUNT), 32'd4);
        check("rr_reg4", 32'(rf_mem[4]), 32'hA4);
        check("rr_reg5", 32'(rf_mem[5]), 32'hB5);

        // Same-address collision: A then B, later write survives.
        do_reset();
        A_REQ = 1'b1; A_ADDR = 3'd2; A_DATA = 8'h11;
        B_REQ = 1'b1; B_ADDR = 3'd2; B_DATA = 8'h22;
        expect_grant(1'b0, 3'd2, 8'h11);
        expect_grant(1'b1, 3'd2, 8'h22);
        @(negedge CLK);
        check("col_a_ack_first", 32'({A_ACK, B_ACK}), 32'b10);
        A_REQ = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("col_b_ack_second", 32'({A_ACK, B_ACK}), 32'b01);
        B_REQ = 1'b0;
        @(negedge CLK);
        check("col_reg2", 32'(rf_mem[2]), 32'h22);
        check("col_wr_count", 32'(WR_COUNT), 32'd2);

        // Mid-write reset after an A grant (PRI now points at B).
        @(negedge CLK);
        A_REQ = 1'b1; A_ADDR = 3'd6; A_DATA = 8'h66;
        expect_grant(1'b0, 3'd6, 8'h66);
        @(negedge CLK);
        check("mwr_in_write", 32'(RF_WRITE), 32'd1);
        A_REQ = 1'b0;
        RESET = 1'b1;
        @(negedge CLK);
        check("mwr_rf_write", 32'(RF_WRITE), 32'd0);
        check("mwr_acks", 32'({A_ACK, B_ACK}), 32'd0);
        check("mwr_wr_count", 32'(WR_COUNT), 32'd0);
        for (int i = 0; i < 8; i++) check("mwr_reg_clear", 32'(rf_mem[i]), 32'h00);
        RESET   = 1'b0;
        exp_cnt = 8'h00;
        // Priority must be back at RR_INIT (A) despite the abandoned A write.
        A_REQ = 1'b1; A_ADDR = 3'd1; A_DATA = 8'h10;
        B_REQ = 1'b1; B_ADDR = 3'd7; B_DATA = 8'h70;
        expect_grant(1'b0, 3'd1, 8'h10);
        @(negedge CLK);
        check("mwr_pri_init", 32'({A_ACK, B_ACK}), 32'b10);
        A_REQ = 1'b0;
        B_REQ = 1'b0;
        @(negedge CLK);

        // Counter wrap: 256 grants from A alone.
        do_reset();
        A_REQ = 1'b1; A_ADDR = 3'd0; A_DATA = 8'hC3;
        for (int g = 0; g < 256; g++) expect_grant(1'b0, 3'd0, 8'hC3);
        acks   = 0;
        cycles = 0;
        while (acks < 256 && cycles < 1000) begin
            @(negedge CLK);
            cycles++;
            if (A_ACK) begin
                acks++;
                if (acks == 255) check("wrap_count_ff", 32'(WR_COUNT), 32'hFF);
                if (acks == 256) begin
                    check("wrap_count_00", 32'(WR_COUNT), 32'h00);
                    A_REQ = 1'b0;
                end
            end
        end
        if (acks < 256) check("wrap_timeout", 32'(acks), 32'd256);
        @(negedge CLK);
        check("wrap_last_gnt", 32'(LAST_GNT), 32'd0);
        check("wrap_reg0", 32'(rf_mem[0]), 32'hC3);
        check("wrap_b_ack", 32'(B_ACK), 32'd0);

        cycles = 0;
        while (sb.size() != 0 && cycles < 20) begin
            @(negedge CLK);
            cycles++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
